// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: ordered reset-release sequencer. All stage resets assert
// together on rst or a software restart, then release one at a time in
// index order, each waiting for its acknowledge (or a timeout) plus a gap.
// Ports: clk, rst (async, active-high), sw_rst_req_i (sync restart level),
//   stage_ack_i[N] (per-stage ready), stage_rst_o[N] (per-stage reset,
//   bit 0 first), busy_o, done_o, timeout_o (sticky ack timeout).
// Build option: RST_SEQ_ACK_SYNC_EN adds a 2-flop synchronizer per ack bit.
module rst_seq_ctrl #(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sw_rst_req_i,
  input  logic [NUM_STAGES-1:0] stage_ack_i,
  output logic [NUM_STAGES-1:0] stage_rst_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o
);

  localparam int MAX_HG =
    (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CMAX =
    (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);
  localparam int KW =
    (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(NUM_STAGES - 1);

  localparam logic [1:0] HOLD     = 2'd0;
  localparam logic [1:0] WAIT_ACK = 2'd1;
  localparam logic [1:0] GAP      = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [KW-1:0]         k;
  logic [KW-1:0]         k_nxt;
  logic [NUM_STAGES-1:0] ack;
  logic                  ack_k;

`ifdef RST_SEQ_ACK_SYNC_EN
  logic [NUM_STAGES-1:0] ack_m;
  logic [NUM_STAGES-1:0] ack_s;

  // An ack from a stage still held in reset is meaningless, so each
  // synchronizer bit is flushed until its stage is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_m <= '0;
      ack_s <= '0;
    end else begin
      ack_m <= stage_ack_i & ~stage_rst_o;
      ack_s <= ack_m & ~stage_rst_o;
    end
  end

  assign ack = ack_s;
`else
  assign ack = stage_ack_i;
`endif

  assign ack_k = ack[k];
  assign k_nxt = k + KW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HOLD;
      cnt         <= '0;
      k           <= '0;
      stage_rst_o <= '1;
      busy_o      <= 1'b1;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else if (sw_rst_req_i) begin
      state       <= HOLD;
      cnt         <= '0;
      k           <= '0;
      stage_rst_o <= '1;
      busy_o      <= 1'b1;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt            <= '0;
            k              <= '0;
            stage_rst_o[0] <= 1'b0;
            state          <= WAIT_ACK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_ACK: begin
          // A timeout advances the sequence exactly like an ack.
          if (ack_k || cnt == ACK_LAST) begin
            if (!ack_k) timeout_o <= 1'b1;
            cnt <= '0;
            if (k == K_LAST) begin
              state  <= DONE;
              done_o <= 1'b1;
              busy_o <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt                <= '0;
            k                  <= k_nxt;
            stage_rst_o[k_nxt] <= 1'b0;
            state              <= WAIT_ACK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed + randomized bench for rst_seq_ctrl, checked
// against a release-schedule model built from the sequencing rules.
module tb_rst_seq_ctrl;

  localparam int NS   = 4;
  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int ATO  = 255;
  localparam int HMAX = 16383;
`ifdef RST_SEQ_ACK_SYNC_EN
  localparam int SPC  = GAP + 3;
  localparam int DLAT = 3;
  localparam int ALAT = 2;
`else
  localparam int SPC  = GAP + 1;
  localparam int DLAT = 1;
  localparam int ALAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [NS-1:0] ack = '0;
  logic [NS-1:0] srst;
  logic          busy;
  logic          done;
  logic          tmo;

  rst_seq_ctrl #(
    .NUM_STAGES  (NS),
    .HOLD_CYCLES (HOLD),
    .STAGE_GAP   (GAP),
    .ACK_TIMEOUT (ATO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw_rst_req_i (req),
    .stage_ack_i  (ack),
    .stage_rst_o  (srst),
    .busy_o       (busy),
    .done_o       (done),
    .timeout_o    (tmo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: edge count since the sequence base, the edge at which each
  // stage was released (0 = still in reset), and the pending release.
  int            t;
  int            rel [NS];
  int            mk;
  int            nrel;
  bit            pend;
  bit            mdone;
  bit            mtmo;
  logic [NS-1:0] ahist [0:HMAX];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_srst"}, 32'(srst), 32'({NS{1'b1}}));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_tmo"},  32'(tmo),  32'd0);
  endtask

  task automatic restart_at(input int e);
    for (int i = 0; i < NS; i++) rel[i] = 0;
    mk    = 0;
    pend  = 1'b1;
    nrel  = e + HOLD;
    mdone = 1'b0;
    mtmo  = 1'b0;
  endtask

  task automatic m_reset();
    t = 0;
    restart_at(0);
  endtask

  // Ack visibility: direct sample, or (synchronized) the sample taken
  // two edges earlier, counted only once the stage had been released.
  function automatic bit seen(input int kk);
    if (ALAT == 0) return ahist[t][kk];
    if (rel[kk] == 0 || rel[kk] > t - 3) return 1'b0;
    return ahist[t-2][kk];
  endfunction

  task automatic m_edge(input logic [NS-1:0] a, input bit r);
    bit s;
    t++;
    if (t <= HMAX) ahist[t] = a;
    if (r) begin
      restart_at(t);
      return;
    end
    if (mdone) return;
    if (pend) begin
      if (t == nrel) begin
        rel[mk] = t;
        pend    = 1'b0;
      end
      return;
    end
    s = seen(mk);
    if (s || t == rel[mk] + ATO) begin
      if (!s) mtmo = 1'b1;
      if (mk == NS - 1) begin
        mdone = 1'b1;
      end else begin
        mk++;
        nrel = t + GAP;
        pend = 1'b1;
      end
    end
  endtask

  function automatic logic [NS-1:0] exp_srst();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = (rel[i] == 0);
    return v;
  endfunction

  task automatic step(input logic [NS-1:0] a, input bit r);
    ack = a;
    req = r;
    @(posedge clk);
    m_edge(a, r);
    @(negedge clk);
    chk("srst", 32'(srst), 32'(exp_srst()));
    chk("busy", 32'(busy), 32'(!mdone));
    chk("done", 32'(done), 32'(mdone));
    chk("tmo",  32'(tmo),  32'(mtmo));
  endtask

  initial begin
    int reld [NS];
    int dne;
    int r0;
    int tr2;
    int tt;
    int ta;
    int stuck;
    logic [NS-1:0] a;

    for (int i = 0; i < NS; i++) rel[i] = 0;
    t = 0;

    // Power-on reset
    repeat (2) @(negedge clk);
    chk_rst("por");

    // Acks tied high: nominal release schedule
    ack = '1;
    rst = 1'b0;
    m_reset();
    for (int i = 0; i < NS; i++) reld[i] = 0;
    dne = 0;
    for (int c = 0; c < 45; c++) begin
      step('1, 1'b0);
      for (int i = 0; i < NS; i++)
        if (reld[i] == 0 && srst[i] == 1'b0) reld[i] = t;
      if (dne == 0 && done) dne = t;
    end
    for (int i = 0; i < NS; i++)
      chk($sformatf("rel_edge%0d", i), 32'(reld[i]), 32'(HOLD + i * SPC));
    chk("done_edge", 32'(dne), 32'(HOLD + (NS - 1) * SPC + DLAT));

    // ack[2] never arrives: timeout after ATO cycles in WAIT_ACK
    step(4'b1011, 1'b1);
    tr2 = 0;
    tt  = 0;
    for (int c = 0; c < 320; c++) begin
      step(4'b1011, 1'b0);
      if (tr2 == 0 && srst[2] == 1'b0) tr2 = t;
      if (tt == 0 && tmo) tt = t;
    end
    chk("tmo_wait", 32'(tt - tr2), 32'(ATO));
    chk("tmo_done", 32'(done), 32'd1);

    // Restart while waiting on stage 1
    step(4'b1101, 1'b1);
    chk_rst("restart_a");
    repeat (30) step(4'b1101, 1'b0);
    step(4'b1101, 1'b1);
    chk_rst("restart_b");
    r0 = t;
    reld[0] = 0;
    for (int c = 0; c < 20; c++) begin
      step(4'b1101, 1'b0);
      if (reld[0] == 0 && srst[0] == 1'b0) reld[0] = t;
    end
    chk("restart_rel0", 32'(reld[0] - r0), 32'(HOLD));

    // ack[1] arrives 10 edges after stage 1 release
    step(4'b1101, 1'b1);
    ta  = 0;
    tr2 = 0;
    for (int c = 0; c < 70; c++) begin
      a = 4'b1101;
      if (rel[1] != 0 && t + 1 >= rel[1] + 10) a[1] = 1'b1;
      if (ta == 0 && a[1]) ta = t + 1;
      step(a, 1'b0);
      if (tr2 == 0 && srst[2] == 1'b0) tr2 = t;
    end
    chk("late_ack_rel", 32'(tr2 - ta + 1), 32'(GAP + 1 + ALAT));
    chk("late_ack_tmo", 32'(tmo), 32'd0);

    // Async rst mid-GAP
    step('1, 1'b1);
    repeat (HOLD + 2) step('1, 1'b0);
    #2 rst = 1'b1;
    #1 chk_rst("async");
    repeat (2) @(negedge clk);
    chk_rst("rst_hold");
    rst = 1'b0;
    m_reset();
    repeat (45) step('1, 1'b0);

    // Randomized acks, stuck stages and occasional restarts
    for (int run = 0; run < 6; run++) begin
      stuck = $urandom_range(0, NS);
      step('1, 1'b1);
      for (int c = 0; c < 250; c++) begin
        for (int i = 0; i < NS; i++)
          a[i] = ($urandom_range(0, 15) == 0);
        if (stuck < NS) a[stuck] = 1'b0;
        step(a, $urandom_range(0, 199) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
